// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divider_pkg
// Description : Shared types for the RV32M iterative divider: operation
//               encoding, FSM state encoding and small op-decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package divider_pkg;

    // RV32M divide/remainder operations as driven by the decoder
    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } divider_op_e;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } divider_state_e;

    // True for the signed variants (DIV, REM)
    function automatic logic op_is_signed(input divider_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    // True when the remainder, not the quotient, is the result
    function automatic logic op_is_rem(input divider_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// ============================================================================
// Module      : divider
// Description : Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
//               One quotient bit per clock; divide-by-zero and signed
//               overflow bypass the iteration and complete in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module divider
    import divider_pkg::*;
#(
    parameter int DataBitwidth    = 32,
    parameter int AddressBitwidth = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [1:0]                 op,
    input  logic [DataBitwidth-1:0]    rs1_data,
    input  logic [DataBitwidth-1:0]    rs2_data,
    input  logic [AddressBitwidth-1:0] rd_in,
    input  logic                       flush,
    output logic                       busy,
    output logic [AddressBitwidth-1:0] rd,
    output logic                       rd_write_enable,
    output logic [DataBitwidth-1:0]    rd_data
);

    localparam int c_cnt_w = (DataBitwidth > 1) ? $clog2(DataBitwidth) : 1;
    localparam logic [c_cnt_w-1:0]      c_cnt_init = c_cnt_w'(DataBitwidth - 1);
    localparam logic [DataBitwidth-1:0] c_min_neg  = {1'b1, {(DataBitwidth-1){1'b0}}};

    divider_state_e              r_state;
    divider_state_e              w_state_next;
    divider_op_e                 r_op;
    logic [AddressBitwidth-1:0]  r_rd;
    logic [c_cnt_w-1:0]          r_cnt;
    logic [DataBitwidth-1:0]     r_quot;
    logic [DataBitwidth-1:0]     r_rem;
    logic [DataBitwidth-1:0]     r_divisor;
    logic                        r_neg_q;
    logic                        r_neg_r;
    logic [DataBitwidth-1:0]     r_rd_data;

    // Request decode on the input side
    divider_op_e                 w_op_in;
    logic                        w_in_signed;
    logic                        w_in_rem;
    logic                        w_a_neg;
    logic                        w_b_neg;
    logic [DataBitwidth-1:0]     w_a_mag;
    logic [DataBitwidth-1:0]     w_b_mag;
    logic                        w_div_zero;
    logic                        w_overflow;
    logic                        w_special;
    logic [DataBitwidth-1:0]     w_special_result;
    logic                        w_accept;

    // Single restoring iteration
    logic [DataBitwidth:0]       w_trial;
    logic                        w_qbit;
    logic [DataBitwidth-1:0]     w_rem_next;
    logic [DataBitwidth-1:0]     w_quot_next;
    logic [DataBitwidth-1:0]     w_q_fix;
    logic [DataBitwidth-1:0]     w_r_fix;
    logic [DataBitwidth-1:0]     w_result;

    assign w_op_in     = divider_op_e'(op);
    assign w_in_signed = op_is_signed(w_op_in);
    assign w_in_rem    = op_is_rem(w_op_in);
    assign w_a_neg     = w_in_signed & rs1_data[DataBitwidth-1];
    assign w_b_neg     = w_in_signed & rs2_data[DataBitwidth-1];
    assign w_a_mag     = w_a_neg ? ('0 - rs1_data) : rs1_data;
    assign w_b_mag     = w_b_neg ? ('0 - rs2_data) : rs2_data;
    assign w_div_zero  = (rs2_data == '0);
    assign w_overflow  = w_in_signed && (rs1_data == c_min_neg) && (rs2_data == '1);
    assign w_special   = w_div_zero | w_overflow;
    assign w_accept    = (r_state == IDLE) && start && !flush;

    // Divide-by-zero wins over overflow: quotient all ones, remainder = dividend
    assign w_special_result = w_div_zero ? (w_in_rem ? rs1_data : '1)
                                         : (w_in_rem ? '0 : c_min_neg);

    // Shift next dividend bit into the partial remainder and try to subtract
    assign w_trial     = {r_rem, r_quot[DataBitwidth-1]} - {1'b0, r_divisor};
    assign w_qbit      = ~w_trial[DataBitwidth];
    assign w_rem_next  = w_qbit ? w_trial[DataBitwidth-1:0]
                                : {r_rem[DataBitwidth-2:0], r_quot[DataBitwidth-1]};
    assign w_quot_next = {r_quot[DataBitwidth-2:0], w_qbit};
    assign w_q_fix     = r_neg_q ? ('0 - w_quot_next) : w_quot_next;
    assign w_r_fix     = r_neg_r ? ('0 - w_rem_next) : w_rem_next;
    assign w_result    = op_is_rem(r_op) ? w_r_fix : w_q_fix;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; flush overrides both new requests and completion
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) w_state_next = w_special ? DONE : CALC;
                CALC:    if (r_cnt == '0) w_state_next = DONE;
                DONE:    w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        busy            = (r_state != IDLE);
        rd_write_enable = (r_state == DONE);
        rd              = r_rd;
        rd_data         = r_rd_data;
    end

    // Datapath: capture magnitudes on accept, iterate in CALC, register the
    // sign-corrected result on the final iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= DIV;
            r_rd      <= '0;
            r_cnt     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_rd_data <= '0;
        end else if (w_accept) begin
            r_op      <= w_op_in;
            r_rd      <= rd_in;
            r_cnt     <= c_cnt_init;
            r_quot    <= w_a_mag;
            r_rem     <= '0;
            r_divisor <= w_b_mag;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            if (w_special) begin
                r_rd_data <= w_special_result;
            end
        end else if ((r_state == CALC) && !flush) begin
            r_quot <= w_quot_next;
            r_rem  <= w_rem_next;
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
                r_rd_data <= w_result;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider
// Description : Scoreboard bench for the iterative divider. Requests push an
//               expected (rd, data, pulse cycle) entry; a negedge monitor
//               pops and compares on every write pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider;

    localparam logic [1:0] c_div  = 2'd0;
    localparam logic [1:0] c_divu = 2'd1;
    localparam logic [1:0] c_rem  = 2'd2;
    localparam logic [1:0] c_remu = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy;
    logic [4:0]  rd;
    logic        rd_write_enable;
    logic [31:0] rd_data;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   ncyc   = 0;

    divider #(.DataBitwidth(32), .AddressBitwidth(5)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .op              (op),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .rd_in           (rd_in),
        .flush           (flush),
        .busy            (busy),
        .rd              (rd),
        .rd_write_enable (rd_write_enable),
        .rd_data         (rd_data)
    );

    always #5 clk = ~clk;

    // Reference model straight from the RV32M rules
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        logic   is_rem;
        is_rem = (o == c_rem) || (o == c_remu);
        if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
        if (o == c_div || o == c_rem) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            if (sa == -64'sd2147483648 && sb == -64'sd1)
                return is_rem ? 32'd0 : 32'h8000_0000;
            q = sa / sb;
            r = sa % sb;
            return is_rem ? r[31:0] : q[31:0];
        end
        return is_rem ? (a % b) : (a / b);
    endfunction

    function automatic bit is_fast(input logic [1:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
        return (b == 32'd0) ||
               ((o == c_div || o == c_rem) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Wait for idle, issue one request, optionally record its expected result
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic [31:0] exp, input bit track);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk); #1;
        while (busy && guard < 100) begin
            @(negedge clk); #1;
            guard++;
        end
        if (busy) begin
            errors++; checks++;
            $display("FAIL idle_timeout: busy=%b required 0", busy);
        end
        start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_in = r;
        if (track) begin
            e.rd   = r;
            e.data = exp;
            e.cyc  = ncyc + 1 + (is_fast(o, a, b) ? 0 : 32);
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        start    = 1'b0;
        rs1_data = $urandom;
        rs2_data = $urandom;
        rd_in    = 5'($urandom);
        op       = 2'($urandom);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    // Monitor: every write pulse must match the oldest outstanding request
    always @(negedge clk) begin
        exp_t e;
        ncyc = ncyc + 1;
        if (rst_n === 1'b1 && rd_write_enable === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: rd=%0d data=%h at cycle %0d, none required",
                         rd, rd_data, ncyc);
            end else begin
                e = sb_q.pop_front();
                if (rd_data !== e.data || rd !== e.rd || ncyc != e.cyc) begin
                    errors++;
                    $display("FAIL result: rd=%0d data=%h cycle=%0d required rd=%0d data=%h cycle=%0d",
                             rd, rd_data, ncyc, e.rd, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        logic [1:0]  o;
        logic [31:0] a, b;
        int          guard;

        rst_n = 1'b0; start = 1'b0; op = 2'd0; rs1_data = '0; rs2_data = '0;
        rd_in = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_we",   {31'd0, rd_write_enable}, 32'd0);
        check("reset_rd",   {27'd0, rd}, 32'd0);
        check("reset_data", rd_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed cases with hand-derived results
        issue(c_divu, 32'd100, 32'd7, 5'd3, 32'd14, 1'b1);
        issue(c_remu, 32'd100, 32'd7, 5'd4, 32'd2, 1'b1);
        issue(c_div,  32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 1'b1);
        issue(c_rem,  32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 1'b1);
        issue(c_div,  32'd7, 32'hFFFF_FFFE, 5'd7, 32'hFFFF_FFFD, 1'b1);
        issue(c_divu, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1'b1);
        issue(c_remu, 32'd5, 32'd0, 5'd9, 32'd5, 1'b1);
        issue(c_div,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1'b1);
        issue(c_rem,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 1'b1);
        issue(c_rem,  32'hFFFF_FFF9, 32'd0, 5'd0, 32'hFFFF_FFF9, 1'b1);

        // Reset mid-operation aborts without a pulse
        issue(c_divu, 32'd100, 32'd7, 5'd12, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_we",   {31'd0, rd_write_enable}, 32'd0);
        check("rst_mid_data", rd_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(c_divu, 32'd9, 32'd3, 5'd13, 32'd3, 1'b1);

        // Flush mid-operation aborts without a pulse
        issue(c_divu, 32'd100, 32'd7, 5'd14, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        issue(c_divu, 32'd9, 32'd3, 5'd15, 32'd3, 1'b1);

        // Start while busy is dropped
        issue(c_divu, 32'd1000, 32'd10, 5'd16, 32'd100, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        start = 1'b1; op = c_remu; rs1_data = 32'd55; rs2_data = 32'd3; rd_in = 5'd17;
        @(posedge clk); #1;
        start = 1'b0;

        // Randomized traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom);
            case ($urandom_range(0, 5))
                0:       begin a = $urandom; b = 32'd0; end
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                3:       begin a = $urandom; b = 32'hFFFF_FFFF - $urandom_range(0, 3); end
                default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
            endcase
            issue(o, a, b, 5'($urandom), ref_div(o, a, b), 1'b1);
        end

        // Drain outstanding results with a bound
        guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
